// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and count limits.
package stopwatch_pkg;

   localparam int VALUE_W = 12;
   localparam logic [VALUE_W-1:0] VALUE_MAX = 12'd4095;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive cycles the synchronized sample disagrees with the
   // accepted level; flip the level once that run reaches DEBOUNCE_CYCLES.
   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            press_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/clear buttons drive an
// IDLE/RUN/PAUSE/DONE machine counting tenths of a second, saturating at 4095.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ          = 100_000_000,
   parameter int TICK_HZ         = 10,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               btn_clear,
   output logic [VALUE_W-1:0] value,
   output logic               running,
   output logic               ovf
);

   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int PRESC_W = $clog2(DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

   logic start_press, clear_press;
   logic start_level, clear_level;
   logic [1:0] unused_levels;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_start),
      .level   (start_level),
      .press   (start_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clear),
      .level   (clear_level),
      .press   (clear_press)
   );

   // Only the press pulses matter here; the accepted levels are not needed.
   assign unused_levels = {start_level, clear_level};

   sw_state_e          state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic               running_q, ovf_q;
   logic               tick;

   // Next-state logic: clear wins over everything; a saturating tick wins
   // over a pause request, otherwise a tick is applied before pausing.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      value_d = value_q;
      tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
      if (clear_press) begin
         state_d = ST_IDLE;
         presc_d = '0;
         value_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_press) begin
                  state_d = ST_RUN;
                  presc_d = '0;
               end
            end
            ST_RUN: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (tick && (value_q == VALUE_MAX)) begin
                  state_d = ST_DONE;
               end else begin
                  if (tick) value_d = value_q + 1'b1;
                  if (start_press) state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start_press) state_d = ST_RUN;
            end
            ST_DONE: begin
            end
         endcase
      end
   end

   // FSM, prescaler, counter and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         value_q   <= '0;
         running_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         value_q   <= value_d;
         running_q <= (state_d == ST_RUN);
         ovf_q     <= (state_d == ST_DONE);
      end
   end

   assign value   = value_q;
   assign running = running_q;
   assign ovf     = ovf_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller that produces the 12-bit binary `value` consumed directly by the 4-digit seven-segment display driver. It debounces two raw push-buttons, runs a start/pause/clear state machine, and counts tenths of a second from 0 to 4095 (0.0 s to 409.5 s). The display driver handles all decimal splitting; this block outputs plain binary only.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 10: count rate in Hz. `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable synchronized samples required to accept a new button level (10 ms at 100 MHz).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_start`  in  1  raw, asynchronous start/pause button; active-high.
- `btn_clear`  in  1  raw, asynchronous clear button; active-high.
- `value`  out  12  elapsed tenths of a second; feeds the display `value` input.
- `running`  out  1  high while in RUN.
- `ovf`  out  1  high while in DONE (the count has saturated).

## Operation
- Each button passes through its own debouncer:
  - 2-flop synchronizer.
  - A stable-counter that resets whenever the synchronized sample equals the accepted level.
  - When the synchronized sample has differed from the accepted level for `DEBOUNCE_CYCLES` consecutive cycles, the accepted level flips.
  - A 0→1 flip of the accepted level emits a one-cycle `press` pulse. Release (1→0) emits nothing.
- State machine has four states: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
  - IDLE: start press → RUN, and the prescaler is zeroed.
  - RUN: start press → PAUSE. The prescaler is held, so a resumed run finishes the partial tick.
  - PAUSE: start press → RUN.
  - DONE: start press is ignored.
  - Any state: clear press → IDLE, with `value`=0 and prescaler=0.
- Prescaler:
  - Counts 0 .. `CLK_HZ/TICK_HZ`-1, and only while in RUN.
  - The cycle it wraps is a tick.
  - On a tick, `value` increments by 1.
- Saturation: a tick with `value`==4095 leaves `value` at 4095 and moves the FSM to DONE. `value` never wraps.
- Simultaneous events:
  - Clear press beats start press in the same cycle.
  - Clear beats a tick in the same cycle.
  - A start press (RUN→PAUSE) in the same cycle as a tick: the tick is applied, then the FSM pauses.
- Reset mid-operation: everything returns to its reset value immediately, including debouncer accepted levels (0) and stable-counters.

## Timing
- Reset values: `value`=0, `running`=0, `ovf`=0. FSM=IDLE, prescaler=0, synchronizers and accepted levels=0.
- All outputs are registered, with no combinational path from input to output.
- Raw press held stable → `press` pulse `DEBOUNCE_CYCLES`+2 to `DEBOUNCE_CYCLES`+3 cycles after the raw edge (the extra cycle depends on sampling phase).
- Glitch shorter than `DEBOUNCE_CYCLES` cycles → no pulse, and the accepted level is unchanged.
- `press` → FSM state change and `running` update on the next edge (1 cycle).
- Value timing in RUN: the first increment lands `CLK_HZ/TICK_HZ` cycles after entering RUN from IDLE. Later increments are spaced exactly `CLK_HZ/TICK_HZ` cycles apart.
- `value` updates on the same edge as the prescaler wrap.
- `ovf` rises on the same edge the FSM enters DONE.

## Structure
- Shared package/header `stopwatch_pkg` holds:
  - the FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - `VALUE_W`=12 and `VALUE_MAX`=4095.
- Sub-module `btn_debounce`, parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst`, `btn_raw`, `level`, `press`.
  - Instantiated twice.
  - Its stable-counter width is derived with `$clog2(DEBOUNCE_CYCLES+1)`.
- Top level holds the FSM, the prescaler (width `$clog2(CLK_HZ/TICK_HZ)`) and the 12-bit counter.

## Test plan
All scenarios use `CLK_HZ`=100, `TICK_HZ`=10, `DEBOUNCE_CYCLES`=4.
- Reset:
  - Stimulus: assert `rst` asynchronously mid-cycle while counting.
  - Response: `value`=0, `running`=0 and `ovf`=0 immediately.
  - After release, a 6-cycle start press gives `running`=1 within 7 cycles.
- Counting and pause:
  - Stimulus: start; wait 55 cycles; pause; wait 100 cycles.
  - Response: `value` stays at 5.
  - Resume, then a 6th increment lands 5 cycles after the resume (partial tick preserved).
- Debounce:
  - Stimulus: 3-cycle start pulses repeated with 3-cycle gaps.
  - Response: no state change.
  - A 5-cycle-stable press toggles the FSM exactly once, and its release does nothing.
- Clear priority:
  - Stimulus: debounced start and clear pulses timed to land in the same cycle, while in PAUSE at `value`=37.
  - Response: IDLE, `value`=0.
  - A clear coinciding with a tick also yields 0.
- Saturation:
  - Stimulus: run for 4096 ticks.
  - Response: `value`=4095 after 4095 ticks. The next tick leaves 4095 with `ovf`=1 and `running`=0.
  - A start press is ignored, and a clear press returns `value`=0 and `ovf`=0.
- Display integration:
  - Stimulus: connect `value` to the display driver and run 1234 ticks.
  - Response: the driver shows digits 1,2,3,4.
